// File: rtl/write_resp_router_2_1.sv
// Tracks which master won each write address and steers B responses back in issue order.
// Latency: zero-cycle B routing; AW issue is held off while the ID FIFO is full.
module write_resp_router_2_1 #(
    parameter int Outstanding_depth = 4,
    parameter int Count_width       = $clog2(Outstanding_depth + 1)
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   Selected_Slave,
    input  logic                   Sel_S_AXI_awvalid,
    output logic                   M_AXI_awvalid,
    input  logic                   M_AXI_awready,
    output logic                   Sel_S_AXI_awready,
    input  logic [1:0]             M_AXI_bresp,
    input  logic                   M_AXI_bvalid,
    output logic                   M_AXI_bready,
    output logic [1:0]             S00_AXI_bresp,
    output logic                   S00_AXI_bvalid,
    input  logic                   S00_AXI_bready,
    output logic [1:0]             S01_AXI_bresp,
    output logic                   S01_AXI_bvalid,
    input  logic                   S01_AXI_bready,
    output logic [Count_width-1:0] Outstanding_count,
    output logic                   Fifo_full,
    output logic                   Orphan_resp
);

    localparam int PTR_W = (Outstanding_depth > 1) ? $clog2(Outstanding_depth) : 1;

    logic [Outstanding_depth-1:0] id_fifo;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [Count_width-1:0]       count;
    logic                         orphan_q;
    logic                         empty;
    logic                         head;
    logic                         push;
    logic                         pop;

    assign empty     = (count == '0);
    assign Fifo_full = (count == Count_width'(Outstanding_depth));
    assign head      = id_fifo[rd_ptr];

    assign M_AXI_awvalid     = Sel_S_AXI_awvalid & ~Fifo_full;
    assign Sel_S_AXI_awready = M_AXI_awready & ~Fifo_full;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
    assign push = Sel_S_AXI_awvalid & M_AXI_awready & ~Fifo_full;
    assign pop  = M_AXI_bvalid & M_AXI_bready;

    assign Outstanding_count = count;
    assign Orphan_resp       = orphan_q;

    // bready depends only on state and master readies, never on bvalid.
    always_comb begin
        S00_AXI_bvalid = 1'b0;
        S00_AXI_bresp  = 2'b00;
        S01_AXI_bvalid = 1'b0;
        S01_AXI_bresp  = 2'b00;
        M_AXI_bready   = 1'b0;
        if (!empty) begin
            if (head) begin
                S01_AXI_bvalid = M_AXI_bvalid;
                S01_AXI_bresp  = M_AXI_bresp;
                M_AXI_bready   = S01_AXI_bready;
            end else begin
                S00_AXI_bvalid = M_AXI_bvalid;
                S00_AXI_bresp  = M_AXI_bresp;
                M_AXI_bready   = S00_AXI_bready;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            id_fifo[wr_ptr] <= Selected_Slave;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            orphan_q <= 1'b0;
        end else begin
            orphan_q <= M_AXI_bvalid & empty;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_write_resp_router_2_1.sv
// Randomized bench: an ordered queue of master IDs predicts routing, counts and orphan pulses.
module tb_write_resp_router_2_1;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          Selected_Slave;
    logic          Sel_S_AXI_awvalid;
    logic          M_AXI_awvalid;
    logic          M_AXI_awready;
    logic          Sel_S_AXI_awready;
    logic [1:0]    M_AXI_bresp;
    logic          M_AXI_bvalid;
    logic          M_AXI_bready;
    logic [1:0]    S00_AXI_bresp;
    logic          S00_AXI_bvalid;
    logic          S00_AXI_bready;
    logic [1:0]    S01_AXI_bresp;
    logic          S01_AXI_bvalid;
    logic          S01_AXI_bready;
    logic [CW-1:0] Outstanding_count;
    logic          Fifo_full;
    logic          Orphan_resp;

    write_resp_router_2_1 #(.Outstanding_depth(DEPTH), .Count_width(CW)) dut (
        .ACLK              (ACLK),
        .ARESET            (ARESET),
        .Selected_Slave    (Selected_Slave),
        .Sel_S_AXI_awvalid (Sel_S_AXI_awvalid),
        .M_AXI_awvalid     (M_AXI_awvalid),
        .M_AXI_awready     (M_AXI_awready),
        .Sel_S_AXI_awready (Sel_S_AXI_awready),
        .M_AXI_bresp       (M_AXI_bresp),
        .M_AXI_bvalid      (M_AXI_bvalid),
        .M_AXI_bready      (M_AXI_bready),
        .S00_AXI_bresp     (S00_AXI_bresp),
        .S00_AXI_bvalid    (S00_AXI_bvalid),
        .S00_AXI_bready    (S00_AXI_bready),
        .S01_AXI_bresp     (S01_AXI_bresp),
        .S01_AXI_bvalid    (S01_AXI_bvalid),
        .S01_AXI_bready    (S01_AXI_bready),
        .Outstanding_count (Outstanding_count),
        .Fifo_full         (Fifo_full),
        .Orphan_resp       (Orphan_resp)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: IDs of writes awaiting a response, oldest first.
    bit ids[$];
    bit orphan_exp;
    bit b_held;

    int aw_pct[4]  = '{90, 30, 95, 60};
    int b_pct[4]   = '{20, 80, 90, 50};
    int rdy_pct[4] = '{50, 90, 30, 80};

    initial begin
        ARESET            = 1'b1;
        Selected_Slave    = 1'b0;
        Sel_S_AXI_awvalid = 1'b0;
        M_AXI_awready     = 1'b0;
        M_AXI_bresp       = 2'b00;
        M_AXI_bvalid      = 1'b0;
        S00_AXI_bready    = 1'b0;
        S01_AXI_bready    = 1'b0;
        orphan_exp        = 1'b0;
        b_held            = 1'b0;
        repeat (2) @(posedge ACLK);

        for (int ph = 0; ph < 4; ph++) begin
            for (int cyc = 0; cyc < 600; cyc++) begin
                int  cnt;
                bit  full, hd, exp_bready, push, pop;
                logic [2:0] exp_b00, exp_b01;

                @(negedge ACLK);
                ARESET            = ($urandom_range(0, 149) == 0);
                Selected_Slave    = 1'($urandom_range(0, 1));
                Sel_S_AXI_awvalid = ($urandom_range(0, 99) < aw_pct[ph]);
                M_AXI_awready     = ($urandom_range(0, 99) < aw_pct[ph]);
                S00_AXI_bready    = ($urandom_range(0, 99) < rdy_pct[ph]);
                S01_AXI_bready    = ($urandom_range(0, 99) < rdy_pct[ph]);
                // A slave holds bvalid/bresp until accepted, unless nothing is outstanding.
                if (!(b_held && ids.size() != 0)) begin
                    M_AXI_bvalid = ($urandom_range(0, 99) < b_pct[ph]);
                    M_AXI_bresp  = 2'($urandom_range(0, 3));
                end
                #1;

                cnt        = ids.size();
                full       = (cnt == DEPTH);
                hd         = (cnt != 0) ? ids[0] : 1'b0;
                exp_bready = (cnt != 0) && (hd ? S01_AXI_bready : S00_AXI_bready);
                exp_b00    = (cnt != 0 && !hd) ? {M_AXI_bvalid, M_AXI_bresp} : 3'b000;
                exp_b01    = (cnt != 0 &&  hd) ? {M_AXI_bvalid, M_AXI_bresp} : 3'b000;

                check("awvalid", 32'(M_AXI_awvalid), 32'(Sel_S_AXI_awvalid && !full));
                check("awready", 32'(Sel_S_AXI_awready), 32'(M_AXI_awready && !full));
                check("s00_b", 32'({S00_AXI_bvalid, S00_AXI_bresp}), 32'(exp_b00));
                check("s01_b", 32'({S01_AXI_bvalid, S01_AXI_bresp}), 32'(exp_b01));
                check("bready", 32'(M_AXI_bready), 32'(exp_bready));
                check("count", 32'(Outstanding_count), 32'(cnt));
                check("full", 32'(Fifo_full), 32'(full));
                check("orphan", 32'(Orphan_resp), 32'(orphan_exp));

                push = Sel_S_AXI_awvalid && M_AXI_awready && !full;
                pop  = M_AXI_bvalid && exp_bready;
                if (ARESET) begin
                    ids.delete();
                    orphan_exp = 1'b0;
                end else begin
                    orphan_exp = M_AXI_bvalid && (cnt == 0);
                    if (pop)  void'(ids.pop_front());
                    if (push) ids.push_back(Selected_Slave);
                end
                b_held = M_AXI_bvalid && !pop;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/write_resp_router_2_1.md
Name: write_resp_router_2_1

Overview:
- Return-path companion to the 2-to-1 write address mux in the AXI4 interconnect datapath.
- Records which master (S00 or S01) won each accepted write address handshake.
- Routes the slave's B-channel responses back to the correct master, in the same order as the address handshakes.
- Gates write address issue when the outstanding-write tracker is full.

Parameters:
- Outstanding_depth, 4, maximum outstanding writes tracked; power of 2, minimum 2.
- Count_width, $clog2(Outstanding_depth+1), width of the outstanding count output.

Ports:
- ACLK  in  1  system clock; all state updates on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- Selected_Slave  in  1  master index of the current muxed AW (0=S00, 1=S01); same select that drives the AW mux.
- Sel_S_AXI_awvalid  in  1  muxed awvalid from the AW mux.
- M_AXI_awvalid  out  1  awvalid to slave = Sel_S_AXI_awvalid & !Fifo_full.
- M_AXI_awready  in  1  awready from slave.
- Sel_S_AXI_awready  out  1  awready back to selected master = M_AXI_awready & !Fifo_full.
- M_AXI_bresp  in  2  write response from slave.
- M_AXI_bvalid  in  1  response valid from slave.
- M_AXI_bready  out  1  response ready to slave.
- S00_AXI_bresp  out  2  response to master 0.
- S00_AXI_bvalid  out  1  response valid to master 0.
- S00_AXI_bready  in  1  response ready from master 0.
- S01_AXI_bresp  out  2  response to master 1.
- S01_AXI_bvalid  out  1  response valid to master 1.
- S01_AXI_bready  in  1  response ready from master 1.
- Outstanding_count  out  Count_width  number of writes awaiting a B response.
- Fifo_full  out  1  Outstanding_count == Outstanding_depth.
- Orphan_resp  out  1  one-cycle pulse: slave asserted bvalid while no write was outstanding.

Behaviour:
- State: Outstanding_depth x 1-bit ID FIFO; wr_ptr and rd_ptr, each log2(depth) bits, wrapping modulo depth; count register.
- Push: on cycle with Sel_S_AXI_awvalid & M_AXI_awready & !Fifo_full, write Selected_Slave at wr_ptr, wr_ptr++.
- Pop: on cycle with M_AXI_bvalid & M_AXI_bready, rd_ptr++.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Fifo_full is computed from the registered count. When full, pushes are blocked even if a pop occurs the same cycle; AW issue resumes the cycle after the pop.
- Routing: combinational, zero latency, when count != 0; head = FIFO[rd_ptr].
  - head=0: S00_AXI_bvalid = M_AXI_bvalid, S00_AXI_bresp = M_AXI_bresp, M_AXI_bready = S00_AXI_bready.
  - head=1: the same mapping onto S01.
  - Non-selected master: bvalid=0, bresp=2'b00.
- Empty (count==0): both master bvalid=0, both bresp=0, M_AXI_bready=0.
  - A response arriving while empty is never accepted or popped.
  - Orphan_resp=1 in the cycle after any cycle with bvalid & empty; 0 otherwise.
- Handshake rules: bvalid and bresp are held by the slave until bready. Routing cannot change while a response is pending, because head only changes on pop.
- Reset: on ACLK edge with ARESET=1, pointers=0, count=0, Orphan_resp=0, FIFO contents don't-care.
  - Resulting outputs: all master bvalid=0, all bresp=0, M_AXI_bready=0, Fifo_full=0, M_AXI_awvalid = Sel_S_AXI_awvalid.
  - Reset mid-operation discards all outstanding entries; responses arriving afterwards are orphans.
- No combinational path from M_AXI_bvalid to M_AXI_bready.

Test Plan:
1. Reset, then one write from S00 (Selected_Slave=0, awvalid, awready for 1 cycle) -> count=1. Slave returns bvalid, bresp=2'b00 -> S00_AXI_bvalid=1, S01_AXI_bvalid=0. S00_AXI_bready=1 -> M_AXI_bready=1, count=0 next cycle.
2. AWs from S01, S00, S01 in order; responses 2'b10, 2'b00, 2'b11 -> delivered to S01 (2'b10), S00 (2'b00), S01 (2'b11) in order; count steps 3,2,1,0.
3. Five back-to-back AWs with awready=1, depth 4 -> after 4 accepts Fifo_full=1, M_AXI_awvalid=0, Sel_S_AXI_awready=0. One B pop -> the fifth AW is accepted the cycle after the pop; wr_ptr wraps to 1.
4. count=2, same-cycle AW accept and B handshake -> count stays 2; the new ID lands at wr_ptr and head advances correctly.
5. count=0, slave asserts bvalid -> M_AXI_bready=0, both master bvalid=0, Orphan_resp=1 for exactly one cycle, then 0.
6. count=3, ARESET high for 1 cycle while bvalid pending -> count=0, all bvalid outputs 0, M_AXI_bready=0. Next cycle: Orphan_resp=1 if bvalid is still high.
